// File: rtl/izh_pkg.sv
// Shared types, constants and sign-magnitude arithmetic for the Izhikevich
// sweep scheduler. Words are 20-bit sign-magnitude with 8 fractional bits
// (MSB = sign), matching the fixed-point arithmetic library.
package izh_pkg;

  localparam int N = 20;
  localparam int Q = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    WB,
    DONE
  } state_t;

  // Izhikevich polynomial coefficients in Q8 sign-magnitude.
  localparam logic [N-1:0] K_0P04 = 20'h0000A;
  localparam logic [N-1:0] K_5    = 20'h00500;
  localparam logic [N-1:0] K_140  = 20'h08C00;

  // Library negator: flip the sign bit only.
  function automatic logic [N-1:0] sm_neg(input logic [N-1:0] x);
    return {~x[N-1], x[N-2:0]};
  endfunction

  // Library adder: same signs add magnitudes (wrapping), opposite signs
  // subtract the smaller magnitude; an exact cancel yields +0.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] x,
                                          input logic [N-1:0] y);
    logic [N-2:0] mag;
    logic         sgn;
    if (x[N-1] == y[N-1]) begin
      mag = x[N-2:0] + y[N-2:0];
      sgn = x[N-1];
    end else if (x[N-2:0] >= y[N-2:0]) begin
      mag = x[N-2:0] - y[N-2:0];
      sgn = (mag == '0) ? 1'b0 : x[N-1];
    end else begin
      mag = y[N-2:0] - x[N-2:0];
      sgn = y[N-1];
    end
    return {sgn, mag};
  endfunction

  // Library multiplier: full magnitude product, drop Q fraction bits and
  // truncate to the magnitude width; sign is the XOR of operand signs.
  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] x,
                                          input logic [N-1:0] y);
    logic [2*(N-1)-1:0] prod;
    prod = {{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, y[N-2:0]};
    return {x[N-1] ^ y[N-1], prod[Q +: (N-1)]};
  endfunction

  // Signed greater-or-equal on sign-magnitude words; -0 and +0 compare equal.
  function automatic logic sm_ge(input logic [N-1:0] x,
                                 input logic [N-1:0] y);
    logic signed [N-1:0] xs;
    logic signed [N-1:0] ys;
    xs = x[N-1] ? -$signed({1'b0, x[N-2:0]}) : $signed({1'b0, x[N-2:0]});
    ys = y[N-1] ? -$signed({1'b0, y[N-2:0]}) : $signed({1'b0, y[N-2:0]});
    return xs >= ys;
  endfunction

endpackage

// File: rtl/izh_neuron_datapath.sv
// Combinational Izhikevich update for one neuron:
//   dv = (0.04 v^2 + 5 v + 140 - w + i) * step
//   dw = a * (b v - w) * step
// Operation order matches the library calc_dv / mult / add / negator chain
// so results are bit-exact with the golden model.
module izh_neuron_datapath
  import izh_pkg::*;
(
  input  logic [N-1:0] v,
  input  logic [N-1:0] w,
  input  logic [N-1:0] i,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] step,
  output logic [N-1:0] dv,
  output logic [N-1:0] dw
);

  logic [N-1:0] v_sq;
  logic [N-1:0] quad_term;
  logic [N-1:0] lin_term;
  logic [N-1:0] dv_sum;
  logic [N-1:0] bv;
  logic [N-1:0] recov;

  // Membrane derivative chain (calc_dv equivalent).
  always_comb begin
    v_sq      = sm_mul(v, v);
    quad_term = sm_mul(K_0P04, v_sq);
    lin_term  = sm_mul(K_5, v);
    dv_sum    = sm_add(quad_term, lin_term);
    dv_sum    = sm_add(dv_sum, K_140);
    dv_sum    = sm_add(dv_sum, sm_neg(w));
    dv_sum    = sm_add(dv_sum, i);
    dv        = sm_mul(dv_sum, step);
  end

  // Recovery derivative chain.
  always_comb begin
    bv    = sm_mul(b, v);
    recov = sm_add(bv, sm_neg(w));
    recov = sm_mul(a, recov);
    dw    = sm_mul(recov, step);
  end

endmodule

// File: rtl/izh_sweep_scheduler.sv
// Time-multiplexed Izhikevich sweep controller. Holds v/w/i for every
// neuron and walks them in index order through one shared datapath,
// spending LOAD/EVAL/WB cycles per neuron. Spike decision, write-back value
// and v_out are presented combinationally during WB so they are visible in
// the same cycle the neuron's state is committed.
module izh_sweep_scheduler
  import izh_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     step,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic [N-1:0]     v_th,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [N-1:0]     cfg_v,
  input  logic [N-1:0]     cfg_w,
  input  logic [N-1:0]     cfg_i,
  output logic             busy,
  output logic             done,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  output logic [N-1:0]     v_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0] k;

  logic [N-1:0] v_mem [NUM_NEURONS];
  logic [N-1:0] w_mem [NUM_NEURONS];
  logic [N-1:0] i_mem [NUM_NEURONS];

  logic [N-1:0] step_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] c_q;
  logic [N-1:0] d_q;
  logic [N-1:0] vth_q;

  logic [N-1:0] v_op;
  logic [N-1:0] w_op;
  logic [N-1:0] i_op;
  logic [N-1:0] dv_q;
  logic [N-1:0] dw_q;
  logic [N-1:0] v_out_q;

  logic [N-1:0] dv;
  logic [N-1:0] dw;
  logic [N-1:0] v_new;
  logic [N-1:0] w_new;
  logic [N-1:0] v_store;
  logic [N-1:0] w_store;
  logic         spike;
  logic         cfg_hit;
  logic         last_neuron;

  assign last_neuron = (k == LAST_IDX);
  assign cfg_hit     = cfg_we && (int'(cfg_idx) < NUM_NEURONS);

  izh_neuron_datapath u_datapath (
    .v    (v_op),
    .w    (w_op),
    .i    (i_op),
    .a    (a_q),
    .b    (b_q),
    .step (step_q),
    .dv   (dv),
    .dw   (dw)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = EVAL;
      EVAL: state_next = WB;
      WB:   state_next = last_neuron ? DONE : LOAD;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write-back arithmetic and spike/reset rule for the current neuron.
  always_comb begin
    v_new   = sm_add(v_op, dv_q);
    w_new   = sm_add(w_op, dw_q);
    spike   = sm_ge(v_new, vth_q);
    v_store = spike ? c_q : v_new;
    w_store = spike ? sm_add(w_new, d_q) : w_new;
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign spike_valid = (state == WB) && spike;
  assign spike_idx   = spike_valid ? k : '0;
  assign v_out       = (state == WB) ? v_store : v_out_q;

  // Sweep parameters and neuron index; parameters are frozen for the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      vth_q  <= '0;
      k      <= '0;
    end else if (state == IDLE && start) begin
      step_q <= step;
      a_q    <= a;
      b_q    <= b;
      c_q    <= c;
      d_q    <= d;
      vth_q  <= v_th;
      k      <= '0;
    end else if (state == WB && !last_neuron) begin
      k <= k + IDX_W'(1);
    end
  end

  // Operand and datapath-result pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_op    <= '0;
      w_op    <= '0;
      i_op    <= '0;
      dv_q    <= '0;
      dw_q    <= '0;
      v_out_q <= '0;
    end else begin
      if (state == LOAD) begin
        v_op <= v_mem[k];
        w_op <= w_mem[k];
        i_op <= i_mem[k];
      end
      if (state == EVAL) begin
        dv_q <= dv;
        dw_q <= dw;
      end
      if (state == WB) v_out_q <= v_store;
    end
  end

  // Neuron state memory: configuration writes only while idle, sweep
  // write-back in WB. i is configuration-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_mem[n] <= '0;
        w_mem[n] <= '0;
        i_mem[n] <= '0;
      end
    end else if (state == IDLE) begin
      if (cfg_hit) begin
        v_mem[cfg_idx] <= cfg_v;
        w_mem[cfg_idx] <= cfg_w;
        i_mem[cfg_idx] <= cfg_i;
      end
    end else if (state == WB) begin
      v_mem[k] <= v_store;
      w_mem[k] <= w_store;
    end
  end

endmodule

// File: doc/izh_sweep_scheduler.md
# izh_sweep_scheduler

Time-multiplexed sequencer for the Izhikevich neuron update. It holds per-neuron state (v, w, i) for NUM_NEURONS neurons and shares one combinational update datapath among them. On each start pulse it performs one Euler timestep over every neuron in index order, applies spike/reset rules, and reports spikes. It sits between the network-level timestep controller and the fixed-point arithmetic library (mult/add/negator, calc_dv).

## Interface
- N, 20, fixed-point word width
- Q, 8, fractional bits (library sign-magnitude format, MSB = sign)
- NUM_NEURONS, 4, neurons served; ≥1
- IDX_W, $clog2(NUM_NEURONS) (min 1), neuron index width
---
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins one sweep when idle
- step  in  N  Euler step size, sampled at start
- a, b, c, d  in  N each  Izhikevich parameters, sampled at start
- v_th  in  N  spike threshold, sampled at start
- cfg_we  in  1  write neuron state when idle
- cfg_idx  in  IDX_W  neuron to write
- cfg_v, cfg_w, cfg_i  in  N each  state/current values to write
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse at sweep end
- spike_valid  out  1  one-cycle pulse per spiking neuron
- spike_idx  out  IDX_W  index of the spiking neuron, valid with spike_valid
- v_out  out  N  post-update v of the neuron just written back

## Operation
- FSM states: IDLE, LOAD, EVAL, WB, DONE; busy = (state != IDLE).
- IDLE: start=1 → latch step/a/b/c/d/v_th, clear k to 0, go to LOAD. start is ignored in every other state.
- LOAD: register v[k], w[k], i[k] into operand registers; go to EVAL.
- EVAL: register dv and dw from the datapath; go to WB. dv = (0.04v²+5v+140−w+i)·step, dw = a·(b·v−w)·step.
- WB: v_new = v+dv, w_new = w+dw, computed with library add.
  - If v_new ≥ v_th (signed compare, sign-magnitude aware; −0 equals +0): store v[k]=c and w[k]=w_new+d, and pulse spike_valid with spike_idx=k.
  - Otherwise store v_new and w_new.
  - v_out = stored v[k].
  - If k==NUM_NEURONS−1 go to DONE, else k++ and go to LOAD.
- DONE: done=1 for one cycle; go to IDLE.
- i[k] is never modified by the sweep.
- Arithmetic wraps/truncates exactly as the library modules do. No saturation is added; the bench must stay in range (|v| ≤ 45 keeps v² representable).
- cfg_we in IDLE writes v/w/i[cfg_idx] at that edge.
- cfg_we while busy is dropped silently.
- cfg_we and start in the same IDLE cycle: the write lands first, and the sweep sees the new value.

## Timing
- Reset values: state=IDLE, busy=0, done=0, spike_valid=0, spike_idx=0, v_out=0, k=0; all v/w/i entries = 0.
- 3 cycles per neuron. With the start edge at cycle 0:
  - busy is high from cycle 1 through cycle 3·NUM_NEURONS+1.
  - done is high at cycle 3·NUM_NEURONS+1.
  - IDLE (start accepted again) from cycle 3·NUM_NEURONS+2.
- spike_valid and v_out update at the WB edge of neuron k, i.e. visible in cycle 3k+3.
- Reset asserted mid-sweep: immediate return to reset values, including state memory. No done pulse and no partial spike are reported.

## Structure
- Package izh_pkg holds:
  - the state enum;
  - fixed-point constants: 0.04 = 20'h0000A, 5 = 20'h00500, 140 = 20'h08C00;
  - a signed-magnitude compare function.
- One sub-module, izh_neuron_datapath: combinational; wraps calc_dv plus a dw chain built from mult/add/negator; inputs v, w, i, a, b, step; outputs dv, dw.
- The controller registers all datapath outputs.

## Test plan
- Reset, then idle 5 cycles → busy=0, done=0, spike_valid=0, v_out=0; cfg_we while busy has no effect.
- NUM_NEURONS=4, start at cycle 0 → busy cycles 1–13, done only at cycle 13; a second start at cycle 5 is ignored.
- Neuron 0: v=−40, w=−8, i=0, step=1, a=0.02, b=0.2, v_th=30 → v[0] ≈ −29.5 (bit-exact vs. library golden model); no spike.
- Neuron 2: v=25, w=0, i=0, c=−65, d=8 → spike_valid at cycle 9 with spike_idx=2; v[2]=−65; w[2]=dw+8 (≈8.08).
- cfg_we (idx 1, v=10) coincident with start → sweep uses v=10 for neuron 1.
- rst_n low at cycle 7 → outputs zero immediately; a new start after release gives full 13-cycle sweep timing.
